id_ex_stage: RTL

ID/EX pipeline register with load-use interlock and EX-stage operand forwarding muxes for the pipelined ARMv8 core. It latches decoded operands and control from ID and presents the latched register numbers to the forwarding unit. It applies the returned ForwardA/ForwardB selects to build the ALU operands and store data. It also stalls IF/ID and inserts a bubble when an instruction needs a register that a load in EX has not yet produced.

---
 rtl/id_ex_stage.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use interlock and EX operand forwarding muxes.
// Latency: ID fields appear on ID_EX_* one cycle later; stall/alu_a/alu_b/store_data are combinational.
// Backpressure: stall holds PC and IF/ID for one cycle while a bubble enters EX; flush overrides stall.
// Optional: define HAZARD_STATS_EN to add the saturating stall_count output.
module id_ex_stage #(
    parameter int          DATA_W   = 64,
    parameter logic [4:0]  ZERO_REG = 5'd31
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [4:0]        id_Rn1,
    input  logic [4:0]        id_Rm2,
    input  logic [4:0]        id_Rd,
    input  logic [DATA_W-1:0] id_RegData1,
    input  logic [DATA_W-1:0] id_RegData2,
    input  logic [DATA_W-1:0] id_SignExt,
    input  logic              id_RegWrite,
    input  logic              id_MemRead,
    input  logic              id_MemWrite,
    input  logic              id_MemtoReg,
    input  logic              id_ALUSrc,
    input  logic [3:0]        id_ALUCtl,
    input  logic [1:0]        ForwardA,
    input  logic [1:0]        ForwardB,
    input  logic [DATA_W-1:0] EX_MEM_ALUResult,
    input  logic [DATA_W-1:0] MEM_WB_WriteData,
    output logic              stall,
    output logic [4:0]        ID_EX_RegisterRn1,
    output logic [4:0]        ID_EX_RegisterRm2,
    output logic [4:0]        ID_EX_RegisterRd,
    output logic              ID_EX_valid,
    output logic              ID_EX_RegWrite,
    output logic              ID_EX_MemRead,
    output logic              ID_EX_MemWrite,
    output logic              ID_EX_MemtoReg,
    output logic [3:0]        ID_EX_ALUCtl,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [DATA_W-1:0] store_data
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]       stall_count
`endif
);

    typedef struct packed {
        logic              valid;
        logic [4:0]        rn1;
        logic [4:0]        rm2;
        logic [4:0]        rd;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              alu_src;
        logic [3:0]        alu_ctl;
        logic [DATA_W-1:0] reg_data1;
        logic [DATA_W-1:0] reg_data2;
        logic [DATA_W-1:0] sign_ext;
    } id_ex_t;

    // A bubble names XZR everywhere so it can never match a consumer's source register.
    function automatic id_ex_t bubble();
        id_ex_t b;
        b            = '0;
        b.rn1        = ZERO_REG;
        b.rm2        = ZERO_REG;
        b.rd         = ZERO_REG;
        return b;
    endfunction

    id_ex_t pipe_q, pipe_d;
    logic   stall_d;

    // Load-use hazard: the load in EX has not produced its data yet; flush kills the consumer anyway.
    always_comb begin
        stall_d = 1'b0;
        if (!flush && pipe_q.valid && pipe_q.mem_read && (pipe_q.rd != ZERO_REG) && id_valid &&
            ((pipe_q.rd == id_Rn1) || (pipe_q.rd == id_Rm2))) begin
            stall_d = 1'b1;
        end
    end

    // Next pipeline contents: flush bubble, then stall bubble, then the decoded instruction.
    always_comb begin
        pipe_d = bubble();
        if (!flush && !stall_d) begin
            pipe_d.valid      = id_valid;
            pipe_d.rn1        = id_Rn1;
            pipe_d.rm2        = id_Rm2;
            pipe_d.rd         = id_Rd;
            pipe_d.reg_write  = id_valid & id_RegWrite;
            pipe_d.mem_read   = id_valid & id_MemRead;
            pipe_d.mem_write  = id_valid & id_MemWrite;
            pipe_d.mem_to_reg = id_valid & id_MemtoReg;
            pipe_d.alu_src    = id_ALUSrc;
            pipe_d.alu_ctl    = id_ALUCtl;
            pipe_d.reg_data1  = id_RegData1;
            pipe_d.reg_data2  = id_RegData2;
            pipe_d.sign_ext   = id_SignExt;
        end
    end

    // ID/EX pipeline register; reset leaves a bubble in EX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= bubble();
        end else begin
            pipe_q <= pipe_d;
        end
    end

    // Forward mux A: 10 takes EX/MEM, 01 takes MEM/WB, 00 and 11 keep the register file value.
    always_comb begin
        case (ForwardA)
            2'b10:   alu_a = EX_MEM_ALUResult;
            2'b01:   alu_a = MEM_WB_WriteData;
            default: alu_a = pipe_q.reg_data1;
        endcase
    end

    // Forward mux B feeds both store data and, unless an immediate is selected, the ALU.
    always_comb begin
        case (ForwardB)
            2'b10:   store_data = EX_MEM_ALUResult;
            2'b01:   store_data = MEM_WB_WriteData;
            default: store_data = pipe_q.reg_data2;
        endcase
    end

    assign alu_b             = pipe_q.alu_src ? pipe_q.sign_ext : store_data;
    assign stall             = stall_d;
    assign ID_EX_RegisterRn1 = pipe_q.rn1;
    assign ID_EX_RegisterRm2 = pipe_q.rm2;
    assign ID_EX_RegisterRd  = pipe_q.rd;
    assign ID_EX_valid       = pipe_q.valid;
    assign ID_EX_RegWrite    = pipe_q.reg_write;
    assign ID_EX_MemRead     = pipe_q.mem_read;
    assign ID_EX_MemWrite    = pipe_q.mem_write;
    assign ID_EX_MemtoReg    = pipe_q.mem_to_reg;
    assign ID_EX_ALUCtl      = pipe_q.alu_ctl;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_count_q, stall_count_d;

    // Count interlock bubbles only; flush bubbles are not hazards. Saturates at all-ones.
    always_comb begin
        stall_count_d = stall_count_q;
        if (stall_d && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    // Hazard statistics register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_q <= 32'd0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;
`endif

endmodule
